// File: rtl/cf_math_pkg.sv
// Index-width helper shared by the adapter and its response FIFO.
package cf_math_pkg;

  function automatic int unsigned idx_width(input int unsigned num_idx);
    return (num_idx > 32'd1) ? unsigned'($clog2(num_idx)) : 32'd1;
  endfunction

endpackage

// File: rtl/fifo_v3.sv
// Circular FIFO with optional fall-through; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter type         dtype        = logic [DATA_WIDTH-1:0],
  parameter int unsigned ADDR_DEPTH   = cf_math_pkg::idx_width(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  testmode_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_DEPTH-1:0] usage_o,
  input  dtype                  data_i,
  input  logic                  push_i,
  output dtype                  data_o,
  input  logic                  pop_i
);

  localparam int unsigned Depth = (DEPTH > 0) ? DEPTH : 1;

  logic [ADDR_DEPTH-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [ADDR_DEPTH:0]   cnt_q, cnt_d;
  logic                  we;
  logic                  unused_testmode;
  dtype                  mem_q [Depth];

  assign unused_testmode = testmode_i;
  assign full_o  = (cnt_q == (ADDR_DEPTH+1)'(Depth));
  assign empty_o = (cnt_q == '0) && !(FALL_THROUGH && push_i);
  assign usage_o = cnt_q[ADDR_DEPTH-1:0];

  always_comb begin
    rd_d   = rd_q;
    wr_d   = wr_q;
    cnt_d  = cnt_q;
    we     = 1'b0;
    data_o = mem_q[rd_q];
    if (push_i && (!full_o || pop_i)) begin
      we    = 1'b1;
      wr_d  = (wr_q == ADDR_DEPTH'(Depth - 1)) ? '0 : wr_q + ADDR_DEPTH'(1);
      cnt_d = cnt_d + (ADDR_DEPTH+1)'(1);
    end
    if (pop_i && (cnt_q != '0)) begin
      rd_d  = (rd_q == ADDR_DEPTH'(Depth - 1)) ? '0 : rd_q + ADDR_DEPTH'(1);
      cnt_d = cnt_d - (ADDR_DEPTH+1)'(1);
    end
    // Fall-through bypass: an empty FIFO hands the pushed word straight out.
    if (FALL_THROUGH && (cnt_q == '0) && push_i) begin
      data_o = data_i;
      if (pop_i) begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        we    = 1'b0;
      end
    end
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
      we    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/cc_ram_stream_adapter.sv
// Valid/ready request stream to fixed-latency RAM port adapter with a
// credit-limited, in-order response buffer.
module cc_ram_stream_adapter #(
  parameter  int unsigned NumWords  = 512,
  parameter  int unsigned DataWidth = 32,
  parameter  int unsigned ByteWidth = 8,
  parameter  int unsigned Latency   = 1,
  parameter  int unsigned FifoDepth = 2,
  localparam int unsigned AddrWidth = cf_math_pkg::idx_width(NumWords),
  localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  input  logic [BeWidth-1:0]   req_be_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DataWidth-1:0] rsp_rdata_o,
  output logic                 rsp_we_o,
  output logic [1:0]           rsp_error_o,
  output logic                 ram_req_o,
  output logic                 ram_we_o,
  output logic [AddrWidth-1:0] ram_addr_o,
  output logic [DataWidth-1:0] ram_wdata_o,
  output logic [BeWidth-1:0]   ram_be_o,
  input  logic [DataWidth-1:0] ram_rdata_i,
  input  logic                 ram_rvalid_i,
  input  logic [1:0]           ram_rerror_i
);

  localparam int unsigned CntWidth = cf_math_pkg::idx_width(FifoDepth + 1);

  typedef logic [AddrWidth-1:0] addr_t;
  typedef logic [DataWidth-1:0] data_t;
  typedef logic [BeWidth-1:0]   be_t;
  typedef struct packed {
    logic       we;
    logic [1:0] error;
    data_t      rdata;
  } rsp_entry_t;

  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [Latency-1:0]  tag_q, tag_d;
  logic [Latency-1:0]  inflight_q, inflight_d;
  logic                accept, pop, fifo_full, fifo_empty;
  rsp_entry_t          push_entry, pop_entry;
  logic [cf_math_pkg::idx_width(FifoDepth)-1:0] unused_usage;

  assign req_ready_o = (cnt_q < CntWidth'(FifoDepth));
  assign accept      = req_valid_i && req_ready_o;

  assign ram_req_o   = accept;
  assign ram_we_o    = req_we_i;
  assign ram_addr_o  = addr_t'(req_addr_i);
  assign ram_wdata_o = data_t'(req_wdata_i);
  assign ram_be_o    = be_t'(req_be_i);

  assign rsp_valid_o = !fifo_empty;
  assign pop         = rsp_valid_o && rsp_ready_i;

  always_comb begin
    cnt_d = cnt_q;
    if (accept && !pop) begin
      cnt_d = cnt_q + CntWidth'(1);
    end else if (!accept && pop) begin
      cnt_d = cnt_q - CntWidth'(1);
    end
  end

  // Stage 0 captures the accepted request; stage Latency-1 lines up with rvalid.
  always_comb begin
    tag_d         = '0;
    inflight_d    = '0;
    tag_d[0]      = accept && req_we_i;
    inflight_d[0] = accept;
    for (int unsigned i = 1; i < Latency; i++) begin
      tag_d[i]      = tag_q[i-1];
      inflight_d[i] = inflight_q[i-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      tag_q      <= '0;
      inflight_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
    end
  end

  always_comb begin
    push_entry.we    = tag_q[Latency-1];
    push_entry.error = tag_q[Latency-1] ? 2'b00 : ram_rerror_i;
    push_entry.rdata = tag_q[Latency-1] ? '0 : ram_rdata_i;
  end

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DATA_WIDTH   ($bits(rsp_entry_t)),
    .DEPTH        (FifoDepth),
    .dtype        (rsp_entry_t)
  ) i_rsp_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (1'b0),
    .testmode_i (1'b0),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .usage_o    (unused_usage),
    .data_i     (push_entry),
    .push_i     (ram_rvalid_i),
    .data_o     (pop_entry),
    .pop_i      (pop)
  );

  assign rsp_we_o    = pop_entry.we;
  assign rsp_error_o = pop_entry.error;
  assign rsp_rdata_o = pop_entry.rdata;

  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    ram_rvalid_i |-> (!fifo_full || pop));
  a_rvalid_inflight: assert property (@(posedge clk_i) disable iff (!rst_ni)
    ram_rvalid_i |-> inflight_q[Latency-1]);
  a_cnt_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    cnt_q <= CntWidth'(FifoDepth));

endmodule

// File: tb/tb_cc_ram_stream_adapter.sv
// Scoreboard bench: driver pushes expected responses from a word-array
// reference model; a monitor pops and compares every response handshake.
module tb_cc_ram_stream_adapter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 9;
  localparam int unsigned BW = 4;
  localparam int unsigned DEPTH = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0, req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [BW-1:0] req_be = '0;
  logic          rsp_ready = 1'b0;
  logic          req_ready, rsp_valid, rsp_we;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_error;
  logic          ram_req, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [BW-1:0] ram_be;
  logic [DW-1:0] ram_rdata, s1_d;
  logic          ram_rvalid, s1_v;
  logic [1:0]    ram_rerror, s1_e;
  logic [DW-1:0] ram_mem [512];

  int unsigned checks = 0, errors = 0;
  int unsigned acc_cnt = 0, pop_cnt = 0;
  int unsigned cyc = 0, last_acc_cyc = 0;
  int unsigned lat_t1 = 0;
  bit          lat_arm = 1'b0;
  logic [34:0] exp_q [$];
  logic [DW-1:0] mem_model [32];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cc_ram_stream_adapter #(
    .NumWords  (512),
    .DataWidth (32),
    .ByteWidth (8),
    .Latency   (2),
    .FifoDepth (3)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .req_be_i     (req_be),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_we_o     (rsp_we),
    .rsp_error_o  (rsp_error),
    .ram_req_o    (ram_req),
    .ram_we_o     (ram_we),
    .ram_addr_o   (ram_addr),
    .ram_wdata_o  (ram_wdata),
    .ram_be_o     (ram_be),
    .ram_rdata_i  (ram_rdata),
    .ram_rvalid_i (ram_rvalid),
    .ram_rerror_i (ram_rerror)
  );

  // Error pattern the RAM model reports for a given word address.
  function automatic logic [1:0] err_of(input logic [AW-1:0] a);
    if (a % 7 == 3) return 2'b01;
    if (a % 13 == 9) return 2'b10;
    return 2'b00;
  endfunction

  // Two-cycle RAM: request registered, then read data registered.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0; s1_d <= '0; s1_e <= '0;
      ram_rvalid <= 1'b0; ram_rdata <= '0; ram_rerror <= '0;
    end else begin
      s1_v <= ram_req;
      s1_d <= ram_mem[ram_addr];
      s1_e <= err_of(ram_addr);
      if (ram_req && ram_we)
        for (int b = 0; b < 4; b++)
          if (ram_be[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      ram_rvalid <= s1_v;
      ram_rdata  <= s1_d;
      ram_rerror <= s1_e;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_accept(input logic we, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wdata, input logic [BW-1:0] be);
    logic [DW-1:0] w;
    if (we) begin
      exp_q.push_back({1'b1, 2'b00, 32'h0});
      w = mem_model[addr[4:0]];
      for (int b = 0; b < 4; b++)
        if (be[b]) w[8*b +: 8] = wdata[8*b +: 8];
      mem_model[addr[4:0]] = w;
    end else begin
      exp_q.push_back({1'b0, err_of(addr), mem_model[addr[4:0]]});
    end
  endtask

  // One clock of stimulus; returns whether the request was accepted.
  task automatic cycle(input logic v, input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input logic [BW-1:0] be,
                       input logic rr, output logic acc);
    @(negedge clk);
    req_valid = v; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    rsp_ready = rr;
    #1;
    check("req_ready_credit", 64'(req_ready), 64'((acc_cnt - pop_cnt) < DEPTH));
    acc = v && req_ready;
    check("ram_req_eq_accept", 64'(ram_req), 64'(acc));
    if (v) check("ram_addr_pass", 64'(ram_addr), 64'(addr));
    if (acc) begin
      acc_cnt++;
      last_acc_cyc = cyc;
      model_accept(we, addr, wdata, be);
    end
  endtask

  task automatic send(input logic we, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wdata, input logic [BW-1:0] be);
    logic acc;
    int n;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      cycle(1'b1, we, addr, wdata, be, 1'b1, acc);
      n++;
    end
    if (!acc) check("send_timeout", 64'(acc), 64'd1);
  endtask

  task automatic drain();
    logic acc;
    for (int n = 0; n < 100 && exp_q.size() != 0; n++)
      cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, acc);
    repeat (3) cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, acc);
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: sample between edges, score every response handshake.
  initial begin
    logic        prev_stall;
    logic [34:0] prev_pl, got;
    prev_stall = 1'b0;
    prev_pl = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        got = {rsp_we, rsp_error, rsp_rdata};
        if (prev_stall) begin
          check("stall_valid_held", 64'(rsp_valid), 64'd1);
          check("stall_payload_stable", 64'(got), 64'(prev_pl));
        end
        if (lat_arm && rsp_valid) begin
          lat_t1 = cyc;
          lat_arm = 1'b0;
        end
        if (rsp_valid && rsp_ready) begin
          pop_cnt++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_rsp: got %h expected none", got);
          end else if (got !== exp_q[0]) begin
            errors++;
            $display("FAIL rsp_data: got %h expected %h", got, exp_q[0]);
            void'(exp_q.pop_front());
          end else begin
            void'(exp_q.pop_front());
          end
        end
        prev_stall = rsp_valid && !rsp_ready;
        prev_pl = got;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic acc;
    int   naccept;
    int unsigned t0;
    for (int i = 0; i < 32; i++) mem_model[i] = '0;

    repeat (3) @(negedge clk);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_ram_req", 64'(ram_req), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, acc);
    check("post_rst_ready", 64'(req_ready), 64'd1);

    // Initialise every word the bench touches.
    for (int a = 0; a < 32; a++) send(1'b1, AW'(a), $urandom, 4'hF);
    drain();

    // Write then read back a full word.
    send(1'b1, 9'd5, 32'hDEADBEEF, 4'hF);
    send(1'b0, 9'd5, '0, '0);
    // Byte-enable merge.
    send(1'b1, 9'd7, 32'hFFFFFFFF, 4'hF);
    send(1'b1, 9'd7, 32'h11223344, 4'b0101);
    send(1'b0, 9'd7, '0, '0);
    drain();

    // Streaming reads and first-response latency.
    lat_arm = 1'b1;
    send(1'b0, 9'd0, '0, '0);
    t0 = last_acc_cyc;
    for (int a = 1; a < 10; a++) send(1'b0, AW'(a), '0, '0);
    drain();
    check("first_rsp_latency", 64'(lat_t1 - t0), 64'd3);

    // Backpressure: the credit limit caps accepts.
    naccept = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, AW'(10 + i), '0, '0, 1'b0, acc);
      if (acc) naccept++;
    end
    check("stall_accepts", 64'(naccept), 64'd3);
    check("stall_ready_low", 64'(req_ready), 64'd0);
    cycle(1'b1, 1'b0, 9'd20, '0, '0, 1'b1, acc);
    check("full_no_accept", 64'(acc), 64'd0);
    cycle(1'b1, 1'b0, 9'd21, '0, '0, 1'b1, acc);
    check("ready_after_pop", 64'(acc), 64'd1);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, AW'(i), '0, '0, 1'b1, acc);
    drain();

    // Reset with reads in flight: nothing stale may appear.
    send(1'b0, 9'd3, '0, '0);
    send(1'b0, 9'd9, '0, '0);
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 1'b0;
    exp_q.delete();
    acc_cnt = 0;
    pop_cnt = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, acc);
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("mid_rst_ready", 64'(req_ready), 64'd1);
    repeat (8) cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, acc);

    // Randomised traffic with random backpressure.
    for (int i = 0; i < 400; i++)
      cycle(($urandom % 4) != 0, ($urandom % 3) == 0, AW'($urandom % 32),
            $urandom, BW'($urandom % 16), ($urandom % 4) != 0, acc);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
